// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder: oversampled mode-0 slave answering READ (0x03)
// from an internal word memory that is preloaded through a backdoor port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | CSB high, waiting for selection
// ST_CMD    | shifting in the 8-bit command on SCK rises
// ST_ADDR   | shifting in the 24-bit byte address on SCK rises
// ST_DATA   | streaming memory bytes out on SCK falls until CSB rises
// ST_IGNORE | unsupported command, discard SCK until CSB rises
module spi_flash_responder #(
   parameter int WORDS = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          spi_csb,
   input  logic          spi_clk,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   output logic          busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

   // Shift register only needs to hold the low address bits (or the command).
   localparam int SRW = (AW + 2 > 8) ? AW + 2 : 8;
   localparam logic [AW+1:0] BADDR_ONE = 1;

   state_t state_q, state_d;

   logic csb_q1, csb_s;
   logic sck_q1, sck_s, sck_d;
   logic mosi_q1, mosi_s;
   logic rise, fall;

   logic [SRW-2:0] rx_sr;
   logic [SRW-1:0] rx_next;
   logic [4:0]     bit_cnt;
   logic [AW+1:0]  baddr;
   logic [7:0]     tx_sr;
   logic           miso_q, oe_q;
   logic           fetch_req, fetch_vld;
   logic [31:0]    mem_q;
   logic [7:0]     byte_sel;

   logic rx_shift, rx_last, addr_done, tx_shift, byte_done;

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csb_q1  <= 1'b1;
         csb_s   <= 1'b1;
         sck_q1  <= 1'b0;
         sck_s   <= 1'b0;
         sck_d   <= 1'b0;
         mosi_q1 <= 1'b0;
         mosi_s  <= 1'b0;
      end else begin
         csb_q1  <= spi_csb;
         csb_s   <= csb_q1;
         sck_q1  <= spi_clk;
         sck_s   <= sck_q1;
         sck_d   <= sck_s;
         mosi_q1 <= spi_mosi;
         mosi_s  <= mosi_q1;
      end
   end

   assign rise    = sck_s & ~sck_d;
   assign fall    = ~sck_s & sck_d;
   assign rx_next = {rx_sr, mosi_s};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (csb_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_CMD;
            ST_CMD: begin
               if (rise && bit_cnt == 5'd7) begin
                  state_d = (rx_next[7:0] == 8'h03) ? ST_ADDR : ST_IGNORE;
               end
            end
            ST_ADDR: begin
               if (rise && bit_cnt == 5'd23) state_d = ST_DATA;
            end
            ST_DATA:   state_d = ST_DATA;
            ST_IGNORE: state_d = ST_IGNORE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_shift  = 1'b0;
      rx_last   = 1'b0;
      addr_done = 1'b0;
      tx_shift  = 1'b0;
      byte_done = 1'b0;
      busy      = (state_q != ST_IDLE);
      if (!csb_s) begin
         case (state_q)
            ST_CMD: begin
               rx_shift = rise;
               rx_last  = rise && (bit_cnt == 5'd7);
            end
            ST_ADDR: begin
               rx_shift  = rise;
               rx_last   = rise && (bit_cnt == 5'd23);
               addr_done = rx_last;
            end
            ST_DATA: begin
               tx_shift  = fall;
               byte_done = fall && (bit_cnt[2:0] == 3'd7);
            end
            default: ;
         endcase
      end
   end

   assign byte_sel = mem_q[{baddr[1:0], 3'b000} +: 8];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_sr     <= '0;
         bit_cnt   <= '0;
         baddr     <= '0;
         tx_sr     <= '0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         fetch_req <= 1'b0;
         fetch_vld <= 1'b0;
      end else begin
         fetch_req <= 1'b0;
         fetch_vld <= fetch_req;
         if (csb_s) begin
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
         end else begin
            if (fetch_vld) tx_sr <= byte_sel;
            if (rx_shift) begin
               rx_sr   <= rx_next[SRW-2:0];
               bit_cnt <= rx_last ? 5'd0 : bit_cnt + 5'd1;
            end
            if (addr_done) begin
               baddr     <= rx_next[AW+1:0];
               fetch_req <= 1'b1;
            end
            if (tx_shift) begin
               miso_q  <= tx_sr[7];
               tx_sr   <= {tx_sr[6:0], 1'b0};
               oe_q    <= 1'b1;
               bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
               if (byte_done) begin
                  baddr     <= baddr + BADDR_ONE;
                  fetch_req <= 1'b1;
               end
            end
         end
      end
   end

   // Read-before-write: a same-cycle backdoor write returns the old word.
   always_ff @(posedge clk) begin
      if (load_we) mem[load_addr] <= load_data;
      if (fetch_req) mem_q <= mem[baddr[AW+1:2]];
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q & ~csb_s;

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR-flash device model; the responder end of the single-bit SPI read link that the flash controller drives.
- Lets SoC builds and benches run boot code from the flash window at 0x100000 without an external flash part.
- Oversamples SCK, CSB and MOSI with the system clock and answers READ (0x03) with bytes from an internal word memory.
- The internal memory is preloaded through a backdoor write port.

Parameters:
- WORDS, 4096: memory depth in 32-bit words; must be a power of 2. Byte space is 4*WORDS.
- AW, 12: log2(WORDS).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- spi_csb  in  1  chip select, active low
- spi_clk  in  1  SPI clock, mode 0
- spi_mosi  in  1  serial data from controller (flash io0)
- spi_miso  out  1  serial data to controller (flash io1)
- spi_miso_oe  out  1  MISO drive enable
- load_we  in  1  backdoor word write strobe
- load_addr  in  AW  backdoor word address
- load_data  in  32  backdoor write data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async, active low. While asserted:
  - spi_miso=0, spi_miso_oe=0, busy=0;
  - state=IDLE; shift, bit and address registers = 0;
  - synchronizers load CSB=1, SCK=0, MOSI=0.
  - Memory contents are not reset.
- Input sync:
  - Two-flop synchronizers on spi_csb, spi_clk, spi_mosi, plus one delayed copy of synced SCK.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
  - Timing requirement: clk >= 8x SCK frequency; each SCK phase >= 4 clk periods.
- CSB high (synced), in any state: next clk goes to IDLE, clears bit counter, spi_miso_oe=0. This takes priority over any edge in the same cycle.
- States:
  - IDLE: wait for synced CSB low, then go to CMD with bit counter 0.
  - CMD: on each rise, shift MOSI in, MSB first. After the 8th rise:
    - 0x03 -> ADDR;
    - any other value (including 0xFF and 0xAB) -> IGNORE.
  - ADDR: on each rise, shift in 24 address bits, MSB first. After the 24th rise:
    - latch byte address = addr[AW+1:0] (upper bits dropped; 0x100000 maps to byte 0 when WORDS=4096);
    - issue the memory read;
    - go to DATA.
  - DATA:
    - Byte fetch: mem[baddr>>2] is read synchronously one clk after the request. byte = word[8*baddr[1:0] +: 8] (little-endian).
    - The byte is loaded into the tx shift register before the next fall.
    - On each fall: spi_miso <= tx[7], tx shifts left, spi_miso_oe=1 (asserted on the first fall in DATA).
    - After the 8th fall of a byte: baddr <= baddr+1 modulo 4*WORDS (wraps to 0 at the end), and the next fetch is issued immediately.
    - Reads continue indefinitely until CSB goes high.
  - IGNORE: discard all SCK activity until CSB goes high; spi_miso_oe stays 0.
- MOSI bits in DATA are ignored.
- Backdoor load: load_we writes mem[load_addr] at posedge clk regardless of state.
  - A collision with a DATA fetch of the same word returns the old word.
- Reset mid-transaction aborts immediately. After release, the next CSB falling edge starts a fresh command.

Test Plan:
- Preload mem[0]=0x03020100, mem[1]=0x07060504; send 0x03, 0x000000, 8 bytes -> MISO bytes 00 01 02 03 04 05 06 07, MSB first. spi_miso_oe=1 only in DATA, 0 within 2 clk of CSB high.
- Read at address 0x100003 -> bytes 03 04 05 (upper address bits dropped, mid-word start, word crossing).
- WORDS=4096, mem[4095]=0xDDCCBBAA: read from 0x003FFE for 4 bytes -> CC DD 00 01 (wrap to byte 0).
- Send 0xFF, then 0xAB with CSB toggling between -> spi_miso_oe stays 0, busy drops after CSB high. A following 0x03 read of address 0 returns 00.
- Raise CSB after 10 address bits, then issue a full read at 0x000004 -> bytes 04 05; no residue from the aborted frame.
- Assert resetn low mid-DATA -> spi_miso=0, spi_miso_oe=0, busy=0 with no clk edge. After release, a read at address 0 returns 00 01 (memory preserved).
